logic_op_accum: RTL and testbench
=================================

Name: logic_op_accum

Overview:
- Parametrised successor to the team's single 2-input AND primitive.
- Implements a registered, W-bit bitwise logic unit with four selectable ops (AND/OR/XOR/NAND).
- Two modes: single-shot (a op b per beat) and accumulate (reduces operand a across a framed burst of beats).
- Valid/ready stream block on both sides; sits between operand producers and downstream checkers/datapath.

Parameters:
- WIDTH, 8, operand/result width in bits (>=1).
- CNT_W, 8, beat-counter width (>=1); counter saturates.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- op  in  2  00 AND, 01 OR, 10 XOR, 11 NAND
- acc_mode  in  1  0 single-shot, 1 accumulate
- in_valid  in  1  input beat valid
- in_ready  out  1  block accepts beat
- in_a  in  WIDTH  operand a
- in_b  in  WIDTH  operand b (single-shot only; ignored in accumulate)
- in_first  in  1  first beat of accumulate frame
- in_last  in  1  last beat of accumulate frame
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_data  out  WIDTH  result
- out_beats  out  CNT_W  beats contributing to result (saturating)
- out_zero  out  1  out_data == 0
- err_frame  out  1  one-cycle framing-error pulse

Behaviour:
- Reset (async on rst_n low, released synchronously by design): state IDLE; out_valid=0, out_data=0, out_beats=0, out_zero=0, err_frame=0; accumulator and counter cleared. Reset mid-frame discards the partial frame, with no output.
- Beat accepted when in_valid && in_ready. in_ready = !out_valid || out_ready (one-entry output register; full throughput when out_ready=1).
- Output held stable while out_valid && !out_ready; transfer when both high.
- NAND = ~(x & y), bitwise over WIDTH.
- Single-shot (acc_mode=0, state IDLE):
  - op, acc_mode sampled per beat.
  - out_data = in_a op in_b, out_valid the next cycle (latency 1).
  - out_beats=1.
  - in_first/in_last ignored.
- Accumulate (acc_mode=1), FSM IDLE/ACCUM:
  - op and acc_mode latched on the frame's first beat; changes during the frame are ignored.
  - First beat: acc <= in_a, cnt <= 1. If in_last is also set, emit in_a with beats=1 and stay IDLE; otherwise go to ACCUM.
  - ACCUM beat: acc <= acc op in_a, cnt <= sat(cnt+1).
  - ACCUM beat with in_last: result = acc op in_a, emitted next cycle; return to IDLE.
  - Counter saturates at 2^CNT_W-1; no wrap.
- Framing errors (err_frame pulses the cycle after the offending beat):
  - IDLE accumulate beat without in_first: treated as a first beat; err_frame=1.
  - ACCUM beat with in_first: partial frame discarded, new frame starts with this beat; err_frame=1.
  - A beat with both in_first and in_last inside ACCUM: partial discarded, single-beat frame emitted; err_frame=1.
- acc_mode=0 beat while in ACCUM: treated as a frame beat, because mode is latched.
- out_zero registered together with out_data.
- No combinational path from in_* to out_*. in_ready depends combinationally only on out_valid/out_ready.

Test Plan:
- Single AND, WIDTH=8: a=0xF0, b=0x3C, op=00 → next cycle out_valid=1, out_data=0x30, out_beats=1, out_zero=0. Repeat with op=11 → 0xCF. With a=0x0F, b=0xF0, op=00 → 0x00, out_zero=1.
- WIDTH=1 truth table, op=00, pairs (0,0),(0,1),(1,0),(1,1) at 1 beat/cycle → 0,0,0,1 on consecutive cycles. Repeat for OR/XOR/NAND with expected truth tables.
- Accumulate XOR frame: a=0x01 (first), 0x02, 0x04 (last), op=10 → single result 0x07, out_beats=3. Toggling op to 00 mid-frame has no effect. CNT_W=2 with a 5-beat AND frame → out_beats=3.
- Backpressure: out_ready=0 for 3 cycles while in_valid=1 → out_data stable, in_ready=0, and the next beat is accepted only after the transfer. No beat lost or duplicated (scoreboard over 100 random beats).
- Framing: in_first mid-frame after 2 beats → err_frame pulses for 1 cycle, output reflects only the new frame. Accumulate beat in IDLE without in_first → err_frame=1 and the beat is treated as first.
- Reset: rst_n low (asynchronous, mid-cycle) after 2 of 4 beats → out_valid=0 immediately, nothing emitted. A following clean 2-beat OR frame 0x10, 0x01 → 0x11, out_beats=2.

Source files
------------

// File: rtl/logic_op_accum.sv
// logic_op_accum
//   Registered W-bit bitwise logic unit (AND/OR/XOR/NAND) with a valid/ready
//   stream on both sides. In single-shot mode each beat produces a op b. In
//   accumulate mode operand a is reduced across a framed burst, and one result
//   is produced per frame.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   op         00 AND, 01 OR, 10 XOR, 11 NAND
//   acc_mode   0 single-shot, 1 accumulate
//   in_valid   input beat valid
//   in_ready   block accepts a beat (depends only on out_valid/out_ready)
//   in_a       operand a
//   in_b       operand b (single-shot only)
//   in_first   first beat of an accumulate frame
//   in_last    last beat of an accumulate frame
//   out_valid  result valid
//   out_ready  downstream accepts the result
//   out_data   result
//   out_beats  number of beats contributing to the result (saturating)
//   out_zero   out_data == 0, registered alongside out_data
//   err_frame  one-cycle pulse after a beat that violated framing
module logic_op_accum #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       op,
  input  logic             acc_mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_first,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] out_beats,
  output logic             out_zero,
  output logic             err_frame
);

  typedef enum logic {IDLE = 1'b0, ACCUM = 1'b1} state_t;

  function automatic logic [WIDTH-1:0] f_logic(input logic [1:0] sel,
                                               input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y);
    logic [WIDTH-1:0] r;
    case (sel)
      2'b00:   r = x & y;
      2'b01:   r = x | y;
      2'b10:   r = x ^ y;
      default: r = ~(x & y);
    endcase
    return r;
  endfunction

  // Beat counter sticks at all-ones rather than wrapping.
  function automatic logic [CNT_W-1:0] f_sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  state_t           r_state;
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic [CNT_W-1:0] r_out_beats;
  logic             r_out_zero;
  logic             r_err;

  logic             w_in_ready;
  logic             w_accept;
  logic [WIDTH-1:0] w_acc_step;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_emit;
  logic [WIDTH-1:0] w_emit_data;
  logic [CNT_W-1:0] w_emit_beats;
  logic             w_err;
  state_t           w_state_nxt;
  logic [1:0]       w_op_nxt;
  logic [WIDTH-1:0] w_acc_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;

  // One-entry output register: a new beat may enter when the slot is empty
  // or is being drained this cycle.
  assign w_in_ready = !r_out_valid || out_ready;
  assign w_accept   = in_valid && w_in_ready;
  assign w_acc_step = f_logic(r_op, r_acc, in_a);
  assign w_cnt_inc  = f_sat_inc(r_cnt);

  always_comb begin
    w_emit       = 1'b0;
    w_emit_data  = '0;
    w_emit_beats = '0;
    w_err        = 1'b0;
    w_state_nxt  = r_state;
    w_op_nxt     = r_op;
    w_acc_nxt    = r_acc;
    w_cnt_nxt    = r_cnt;
    if (w_accept) begin
      if (r_state == IDLE && !acc_mode) begin
        w_emit       = 1'b1;
        w_emit_data  = f_logic(op, in_a, in_b);
        w_emit_beats = CNT_W'(1);
      end else if (r_state == IDLE || in_first) begin
        // Frame start. Missing in_first in IDLE, or in_first arriving inside
        // a frame (partial frame dropped), both flag a framing error.
        w_err     = (r_state == ACCUM) || !in_first;
        w_op_nxt  = op;
        w_acc_nxt = in_a;
        w_cnt_nxt = CNT_W'(1);
        if (in_last) begin
          w_emit       = 1'b1;
          w_emit_data  = in_a;
          w_emit_beats = CNT_W'(1);
          w_state_nxt  = IDLE;
        end else begin
          w_state_nxt  = ACCUM;
        end
      end else begin
        // Continuing frame; acc_mode is ignored here since mode is latched.
        w_acc_nxt = w_acc_step;
        w_cnt_nxt = w_cnt_inc;
        if (in_last) begin
          w_emit       = 1'b1;
          w_emit_data  = w_acc_step;
          w_emit_beats = w_cnt_inc;
          w_state_nxt  = IDLE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_op        <= 2'b00;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_beats <= '0;
      r_out_zero  <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_op    <= w_op_nxt;
      r_acc   <= w_acc_nxt;
      r_cnt   <= w_cnt_nxt;
      r_err   <= w_err;
      // A result only appears on an accepted beat, which implies the slot is
      // free, so loading never overwrites an untransferred result.
      if (w_emit) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_emit_data;
        r_out_beats <= w_emit_beats;
        r_out_zero  <= (w_emit_data == '0);
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_beats = r_out_beats;
  assign out_zero  = r_out_zero;
  assign err_frame = r_err;

endmodule

// File: tb/tb_logic_op_accum.sv
// Testbench for logic_op_accum: an 8-bit instance (8-bit counter) and a
// 1-bit instance (2-bit counter) driven with directed vectors plus a short
// random single-shot stream checked against a queue.
module tb_logic_op_accum;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic [1:0] op8;  logic mode8, iv8, ir8, f8, l8, ov8, or8, oz8, ef8;
  logic [7:0] a8, b8, od8, ob8;
  logic [1:0] op1;  logic mode1, iv1, ir1, f1, l1, ov1, or1, oz1, ef1;
  logic       a1, b1, od1;
  logic [1:0] ob1;

  int n_chk  = 0;
  int n_fail = 0;

  logic_op_accum #(.WIDTH(8), .CNT_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .op(op8), .acc_mode(mode8), .in_valid(iv8),
    .in_ready(ir8), .in_a(a8), .in_b(b8), .in_first(f8), .in_last(l8),
    .out_valid(ov8), .out_ready(or8), .out_data(od8), .out_beats(ob8),
    .out_zero(oz8), .err_frame(ef8));

  logic_op_accum #(.WIDTH(1), .CNT_W(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .op(op1), .acc_mode(mode1), .in_valid(iv1),
    .in_ready(ir1), .in_a(a1), .in_b(b1), .in_first(f1), .in_last(l1),
    .out_valid(ov1), .out_ready(or1), .out_data(od1), .out_beats(ob1),
    .out_zero(oz1), .err_frame(ef1));

  task automatic check_eq(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat8(input logic [1:0] o, input logic m, input logic [7:0] a,
                       input logic [7:0] b, input logic f, input logic l);
    iv8 = 1'b1; op8 = o; mode8 = m; a8 = a; b8 = b; f8 = f; l8 = l;
    tick();
  endtask

  task automatic idle8();
    iv8 = 1'b0;
    tick();
  endtask

  function automatic logic [7:0] model_op(input logic [1:0] o,
                                          input logic [7:0] x, input logic [7:0] y);
    case (o)
      2'b00:   return x & y;
      2'b01:   return x | y;
      2'b10:   return x ^ y;
      default: return ~(x & y);
    endcase
  endfunction

  // Expected truth tables, bit k is the result for pair k = {a,b}.
  logic [3:0] tt [4];
  logic [1:0] kk;
  logic [7:0] sb_q [$];
  logic [7:0] sb_exp;
  int n_in, n_out, cyc;

  initial begin
    tt[0] = 4'b1000; tt[1] = 4'b1110; tt[2] = 4'b0110; tt[3] = 4'b0111;
    op8 = 0; mode8 = 0; iv8 = 0; a8 = 0; b8 = 0; f8 = 0; l8 = 0; or8 = 1;
    op1 = 0; mode1 = 0; iv1 = 0; a1 = 0; b1 = 0; f1 = 0; l1 = 0; or1 = 1;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    check_eq("rst_ov", ov8, 0);
    check_eq("rst_od", od8, 0);
    check_eq("rst_ob", ob8, 0);
    check_eq("rst_oz", oz8, 0);
    check_eq("rst_ef", ef8, 0);
    check_eq("rst_ov1", ov1, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Single-shot on the 8-bit instance
    beat8(2'b00, 1'b0, 8'hF0, 8'h3C, 1'b0, 1'b0);
    check_eq("and_ov", ov8, 1);
    check_eq("and_od", od8, 8'h30);
    check_eq("and_ob", ob8, 1);
    check_eq("and_oz", oz8, 0);
    beat8(2'b11, 1'b0, 8'hF0, 8'h3C, 1'b0, 1'b0);
    check_eq("nand_od", od8, 8'hCF);
    check_eq("nand_oz", oz8, 0);
    beat8(2'b00, 1'b0, 8'h0F, 8'hF0, 1'b1, 1'b1);
    check_eq("zero_od", od8, 8'h00);
    check_eq("zero_oz", oz8, 1);
    check_eq("zero_ef", ef8, 0);
    idle8();
    check_eq("idle_ov", ov8, 0);

    // 1-bit truth tables, one beat per cycle
    for (int o = 0; o < 4; o++) begin
      for (int k = 0; k < 4; k++) begin
        kk = 2'(k);
        iv1 = 1'b1; mode1 = 1'b0; op1 = 2'(o); a1 = kk[1]; b1 = kk[0];
        tick();
        check_eq($sformatf("tt%0d_%0d_ov", o, k), ov1, 1);
        check_eq($sformatf("tt%0d_%0d_od", o, k), od1, tt[o][k]);
      end
    end
    iv1 = 1'b0;
    tick();

    // Accumulate XOR frame with op toggled mid-frame
    beat8(2'b10, 1'b1, 8'h01, 8'hFF, 1'b1, 1'b0);
    check_eq("xacc_hold", ov8, 0);
    beat8(2'b00, 1'b1, 8'h02, 8'hFF, 1'b0, 1'b0);
    check_eq("xacc_hold2", ov8, 0);
    beat8(2'b00, 1'b0, 8'h04, 8'hFF, 1'b0, 1'b1);
    check_eq("xacc_ov", ov8, 1);
    check_eq("xacc_od", od8, 8'h07);
    check_eq("xacc_ob", ob8, 3);
    check_eq("xacc_ef", ef8, 0);
    idle8();
    check_eq("xacc_once", ov8, 0);

    // Saturating 2-bit counter over a 5-beat AND frame
    for (int k = 0; k < 5; k++) begin
      iv1 = 1'b1; mode1 = 1'b1; op1 = 2'b00; a1 = 1'b1; b1 = 1'b0;
      f1 = (k == 0); l1 = (k == 4);
      tick();
    end
    check_eq("sat_ov", ov1, 1);
    check_eq("sat_od", od1, 1);
    check_eq("sat_ob", ob1, 3);
    iv1 = 1'b0;
    tick();

    // Backpressure: result held, input stalled, then both move together
    or8 = 1'b0;
    beat8(2'b01, 1'b0, 8'hAA, 8'h0F, 1'b0, 1'b0);
    check_eq("bp_ov", ov8, 1);
    check_eq("bp_od", od8, 8'hAF);
    iv8 = 1'b1; op8 = 2'b10; a8 = 8'h11; b8 = 8'h22;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_eq($sformatf("bp_ir_%0d", k), ir8, 0);
      check_eq($sformatf("bp_hold_%0d", k), od8, 8'hAF);
      check_eq($sformatf("bp_ovh_%0d", k), ov8, 1);
    end
    or8 = 1'b1;
    #1;
    check_eq("bp_ir_rel", ir8, 1);
    @(posedge clk); #1;
    check_eq("bp_next_od", od8, 8'h33);
    check_eq("bp_next_ov", ov8, 1);
    idle8();
    check_eq("bp_no_dup", ov8, 0);

    // Random single-shot stream with random backpressure
    n_in = 0; n_out = 0; cyc = 0;
    while ((n_in < 100 || sb_q.size() > 0 || ov8) && cyc < 3000) begin
      iv8 = (n_in < 100) ? 1'($urandom_range(0, 1)) : 1'b0;
      mode8 = 1'b0; f8 = 1'b0; l8 = 1'b0;
      op8 = 2'($urandom_range(0, 3));
      a8 = 8'($urandom_range(0, 255));
      b8 = 8'($urandom_range(0, 255));
      or8 = ($urandom_range(0, 3) != 0);
      #1;
      if (ov8 && or8) begin
        if (sb_q.size() == 0) begin
          check_eq("sb_extra", 1, 0);
        end else begin
          sb_exp = sb_q.pop_front();
          check_eq("sb_data", od8, sb_exp);
        end
        n_out++;
      end
      if (iv8 && ir8) begin
        sb_q.push_back(model_op(op8, a8, b8));
        n_in++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    check_eq("sb_count", n_out, 100);
    check_eq("sb_budget", (cyc < 3000), 1);
    or8 = 1'b1;
    idle8();

    // Framing: in_first arriving inside a frame restarts it
    beat8(2'b01, 1'b1, 8'h01, 8'h00, 1'b1, 1'b0);
    beat8(2'b01, 1'b1, 8'h02, 8'h00, 1'b0, 1'b0);
    beat8(2'b01, 1'b1, 8'h10, 8'h00, 1'b1, 1'b0);
    check_eq("fr_ef", ef8, 1);
    check_eq("fr_ov", ov8, 0);
    beat8(2'b01, 1'b1, 8'h20, 8'h00, 1'b0, 1'b1);
    check_eq("fr_ef_pulse", ef8, 0);
    check_eq("fr_ov2", ov8, 1);
    check_eq("fr_od", od8, 8'h30);
    check_eq("fr_ob", ob8, 2);
    idle8();
    // Accumulate beat in IDLE without in_first is taken as a first beat
    beat8(2'b00, 1'b1, 8'h05, 8'h00, 1'b0, 1'b1);
    check_eq("nf_ef", ef8, 1);
    check_eq("nf_ov", ov8, 1);
    check_eq("nf_od", od8, 8'h05);
    check_eq("nf_ob", ob8, 1);
    idle8();
    check_eq("nf_ef_clr", ef8, 0);

    // Asynchronous reset mid-frame
    beat8(2'b00, 1'b1, 8'hFF, 8'h00, 1'b1, 1'b0);
    beat8(2'b00, 1'b1, 8'h0F, 8'h00, 1'b0, 1'b0);
    iv8 = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_eq("mrst_ov", ov8, 0);
    check_eq("mrst_od", od8, 0);
    check_eq("mrst_ob", ob8, 0);
    tick();
    rst_n = 1'b1;
    tick();
    check_eq("mrst_no_emit", ov8, 0);
    beat8(2'b01, 1'b1, 8'h10, 8'h00, 1'b1, 1'b0);
    check_eq("post_ef", ef8, 0);
    check_eq("post_hold", ov8, 0);
    beat8(2'b01, 1'b1, 8'h01, 8'h00, 1'b0, 1'b1);
    check_eq("post_ov", ov8, 1);
    check_eq("post_od", od8, 8'h11);
    check_eq("post_ob", ob8, 2);
    check_eq("post_ef2", ef8, 0);
    idle8();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1);
  end

endmodule
